fp16_mac_result_capture: RTL
============================

// Module: fp16_mac_result_capture
// PURPOSE
//  Receive-side companion of the fp16 MAC: tracks operand issues through the MAC pipeline, captures the
//  m_50 (product) / a_50 (accumulator) result pair on the cycle it becomes valid, and tags it with a
//  sequence number. Results are buffered in a FIFO and drained downstream over a valid/ready interface.
//  Sits between fp16 MAC outputs and any consumer (result checker, writeback, host readout).
// PARAMETERS
//  MAC_LAT  2  cycles from in_valid_50 (operands at MAC inputs) to matching m_50/a_50 valid; >=1
//  DEPTH    8  FIFO entries; power of two, >=2
//  TAG_W    8  width of sequence tag and drop counter
// PORTS
//  clk_50        in   1                   clock, all logic rising-edge
//  reset_50      in   1                   synchronous, active-high reset
//  in_valid_50   in   1                   operand pair x_50/y_50 issued to MAC this cycle
//  m_50          in   16                  MAC product output (fp16)
//  a_50          in   16                  MAC accumulator output (fp16)
//  out_valid_50  out  1                   FIFO head entry present
//  out_ready_50  in   1                   consumer accepts head when out_valid_50=1
//  out_m_50      out  16                  head product
//  out_a_50      out  16                  head accumulator
//  out_tag_50    out  TAG_W               head sequence tag
//  out_flags_50  out  4                   head flags {a_nan,a_inf,m_nan,m_inf}
//  level_50      out  $clog2(DEPTH)+1     current FIFO occupancy
//  overflow_50   out  1                   sticky: a result was dropped
//  drop_cnt_50   out  TAG_W               saturating count of dropped results
// BEHAVIOUR
//  - Reset (synchronous): delay line, FIFO pointers, level, tag counter, overflow, drop_cnt cleared;
//    all outputs 0. Reset mid-operation flushes FIFO and discards in-flight results; no push occurs
//    for issues made before or during reset.
//  - Valid delay line: MAC_LAT-stage shift register of in_valid_50; cap = stage MAC_LAT output.
//    m_50/a_50 sampled in the cycle cap=1 (MAC outputs are valid then).
//  - Tag: tag counter increments on every cap=1 cycle (pushed or dropped), wraps modulo 2^TAG_W.
//  - Push: on cap=1, {tag,m_50,a_50,flags} written at clock edge if not full, or if full and a pop
//    occurs same cycle (full + push + pop -> level unchanged, no drop).
//  - Drop: cap=1, full, no pop -> entry discarded, overflow_50 set (sticky until reset),
//    drop_cnt_50 += 1 saturating at all-ones.
//  - Pop: out_valid_50 & out_ready_50 at clock edge. out_ready_50 while empty is ignored.
//  - Output: show-ahead; out_m/a/tag/flags reflect head whenever out_valid_50=1, held stable until
//    popped; undefined-but-stable (last value) when empty. Entry pushed at edge N is visible after
//    edge N (out_valid_50 high in cycle N+1). Total latency issue->out_valid = MAC_LAT+1 cycles.
//  - Empty + push + pop same cycle: pop ignored, push taken (level 0->1).
//  - level_50 = pushes - pops, 0..DEPTH; pointers wrap modulo DEPTH.
// CONFIGURATION
//  FP16_CAP_FLAGS_EN defined: flags computed from sampled values at push time and stored per entry:
//    nan = exp==5'h1f & mant!=0; inf = exp==5'h1f & mant==0 (sign ignored).
//  Undefined: flag storage omitted, out_flags_50 tied to 4'b0000; port list unchanged.
// TESTING (MAC_LAT=2, DEPTH=4, TAG_W=8)
//  1 Reset: hold reset_50 2 cycles -> out_valid_50=0, level_50=0, overflow_50=0, drop_cnt_50=0.
//  2 Single: in_valid_50 pulse cycle 0; cycle 2 m_50=16'h3452,a_50=16'h3c00 -> cycle 3 out_valid_50=1,
//    out_m=3452,out_a=3c00,out_tag=00; out_ready=1 -> cycle 4 out_valid_50=0, level 0.
//  3 Overflow: 6 back-to-back issues, out_ready=0 -> level 4, tags 00..03 in order,
//    overflow_50=1, drop_cnt_50=2; next capture tagged 06.
//  4 Full push+pop: FIFO full, cap=1 and out_ready=1 same cycle -> level stays 4, drop_cnt unchanged,
//    new entry at tail, head advances one tag.
//  5 Flags (macro on): m_50=16'h7c00, a_50=16'h7e00 -> out_flags_50=4'b1001; m_50=16'hfc00,
//    a_50=16'h3c00 -> 4'b0001; macro off -> 4'b0000 for both.
//  6 Reset mid-stream: 3 issues, reset_50 asserted 1 cycle before their captures -> no entries
//    appear after reset, level 0, next captured tag 00.

Source files
------------

// File: rtl/fp16_mac_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mac_result_capture
// Purpose  : Receive-side companion of the fp16 MAC. Follows operand issues
//            through the MAC pipeline and captures the m_50/a_50 result pair
//            in the cycle it becomes valid. Each captured pair gets a
//            sequence tag and is buffered in a show-ahead FIFO. The FIFO is
//            drained downstream over a valid/ready interface.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAC_LAT  cycles from in_valid_50 to the matching m_50/a_50 (>=1)
//   DEPTH    FIFO entries (power of two, >=2)
//   TAG_W    width of the sequence tag and of the drop counter
// Ports
//   clk_50        in   clock, all logic on the rising edge
//   reset_50      in   synchronous active-high reset
//   in_valid_50   in   operand pair issued to the MAC this cycle
//   m_50, a_50    in   MAC product / accumulator outputs (fp16)
//   out_valid_50  out  a FIFO head entry is present
//   out_ready_50  in   consumer accepts the head entry
//   out_m_50      out  head product
//   out_a_50      out  head accumulator
//   out_tag_50    out  head sequence tag
//   out_flags_50  out  head flags {a_nan, a_inf, m_nan, m_inf}
//   level_50      out  FIFO occupancy, 0..DEPTH
//   overflow_50   out  sticky: a result was dropped
//   drop_cnt_50   out  saturating count of dropped results
// Build option
//   FP16_CAP_FLAGS_EN : when defined, NaN/Inf flags are classified at push
//                       time and stored with each entry. When undefined,
//                       out_flags_50 is tied to zero.
// ============================================================================
module fp16_mac_result_capture #(
   parameter int MAC_LAT = 2,
   parameter int DEPTH   = 8,
   parameter int TAG_W   = 8
) (
   input  logic                     clk_50,
   input  logic                     reset_50,
   input  logic                     in_valid_50,
   input  logic [15:0]              m_50,
   input  logic [15:0]              a_50,
   output logic                     out_valid_50,
   input  logic                     out_ready_50,
   output logic [15:0]              out_m_50,
   output logic [15:0]              out_a_50,
   output logic [TAG_W-1:0]         out_tag_50,
   output logic [3:0]               out_flags_50,
   output logic [$clog2(DEPTH):0]   level_50,
   output logic                     overflow_50,
   output logic [TAG_W-1:0]         drop_cnt_50
);

   localparam int          AW           = $clog2(DEPTH);
   localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

   logic [MAC_LAT-1:0] r_vld_dly;
   logic               w_cap;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;

   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_level;
   logic [TAG_W-1:0]   r_tag;
   logic               r_overflow;
   logic [TAG_W-1:0]   r_drop_cnt;

   logic [15:0]        r_mem_m   [DEPTH];
   logic [15:0]        r_mem_a   [DEPTH];
   logic [TAG_W-1:0]   r_mem_tag [DEPTH];

   // Valid delay line. Clearing it on reset discards every in-flight issue,
   // and an issue made during reset never enters it.
   generate
      if (MAC_LAT == 1) begin : g_lat_one
         always_ff @(posedge clk_50) begin
            if (reset_50) r_vld_dly <= '0;
            else          r_vld_dly <= in_valid_50;
         end
      end else begin : g_lat_multi
         always_ff @(posedge clk_50) begin
            if (reset_50) r_vld_dly <= '0;
            else          r_vld_dly <= {r_vld_dly[MAC_LAT-2:0], in_valid_50};
         end
      end
   endgenerate

   assign w_cap  = r_vld_dly[MAC_LAT-1];
   assign w_full = (r_level == c_full_level);
   // A ready while the FIFO is empty is ignored because out_valid_50 is low.
   assign w_pop  = out_valid_50 & out_ready_50;
   // A full FIFO can still accept a push when the head leaves in the same cycle.
   assign w_push = w_cap & (~w_full | w_pop);
   assign w_drop = w_cap & w_full & ~w_pop;

   always_ff @(posedge clk_50) begin
      if (reset_50) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_tag      <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
         // The tag counts every capture, so a gap in the tags marks a drop.
         if (w_cap)  r_tag <= r_tag + TAG_W'(1);
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {TAG_W{1'b1}}) r_drop_cnt <= r_drop_cnt + TAG_W'(1);
         end
      end
   end

   // The storage is cleared on reset so that every output reads zero afterwards.
   always_ff @(posedge clk_50) begin
      if (reset_50) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_m[i]   <= '0;
            r_mem_a[i]   <= '0;
            r_mem_tag[i] <= '0;
         end
      end else if (w_push) begin
         r_mem_m[r_wr_ptr]   <= m_50;
         r_mem_a[r_wr_ptr]   <= a_50;
         r_mem_tag[r_wr_ptr] <= r_tag;
      end
   end

`ifdef FP16_CAP_FLAGS_EN
   logic [3:0] r_mem_flags [DEPTH];
   logic [3:0] w_push_flags;

   // Returns {nan, inf}. The sign bit is ignored.
   function automatic logic [1:0] fp16_class(input logic [15:0] v);
      logic exp_max;
      exp_max = (v[14:10] == 5'h1f);
      return {exp_max & (v[9:0] != 10'h000), exp_max & (v[9:0] == 10'h000)};
   endfunction

   assign w_push_flags = {fp16_class(a_50), fp16_class(m_50)};

   always_ff @(posedge clk_50) begin
      if (reset_50) begin
         for (int i = 0; i < DEPTH; i++) r_mem_flags[i] <= '0;
      end else if (w_push) begin
         r_mem_flags[r_wr_ptr] <= w_push_flags;
      end
   end

   assign out_flags_50 = r_mem_flags[r_rd_ptr];
`else
   assign out_flags_50 = 4'b0000;
`endif

   // Show-ahead: the head entry is read straight out of storage.
   assign out_valid_50 = (r_level != '0);
   assign out_m_50     = r_mem_m[r_rd_ptr];
   assign out_a_50     = r_mem_a[r_rd_ptr];
   assign out_tag_50   = r_mem_tag[r_rd_ptr];
   assign level_50     = r_level;
   assign overflow_50  = r_overflow;
   assign drop_cnt_50  = r_drop_cnt;

endmodule
`default_nettype wire
